// File: rtl/pipe_chain.sv
// pipe_chain: elastic register chain of DEPTH stages, each WIDTH bits wide,
// used as the inter-stage latch set of the CPU pipeline.
//
// Every stage keeps its own valid bit. The chain applies valid/ready
// backpressure. Empty stages (bubbles) collapse toward the output end, and
// each stage can be flushed on its own. The block also reports a registered
// count of occupied stages and a saturating count of valid entries destroyed
// by flush.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   in_valid      upstream offers in_data
//   in_ready      chain accepts in_data this cycle
//   in_data       payload entering stage 0
//   out_valid     stage DEPTH-1 holds valid data
//   out_ready     downstream consumes out_data this cycle (low = stall)
//   out_data      payload of stage DEPTH-1
//   flush         bit i kills stage i at the next edge
//   occupancy     number of valid stages
//   flush_cnt     saturating count of valid entries killed by flush
//   flush_cnt_clr synchronous clear of flush_cnt (wins over the increment)
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16,
  localparam int OCCW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] flush,
  output logic [OCCW-1:0]  occupancy,
  output logic [CNTW-1:0]  flush_cnt,
  input  logic             flush_cnt_clr
);

  // The sum is wide enough that neither operand can overflow it before the
  // saturation compare.
  localparam int SUMW = ((CNTW + 1) > (OCCW + 1)) ? (CNTW + 1) : (OCCW + 1);

  function automatic logic [OCCW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [OCCW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + OCCW'(bits[i]);
    end
    return n;
  endfunction

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                              input logic [OCCW-1:0] b);
    logic [SUMW-1:0] sum;
    sum = SUMW'(a) + SUMW'(b);
    if (sum > SUMW'({CNTW{1'b1}})) begin
      return {CNTW{1'b1}};
    end
    return sum[CNTW-1:0];
  endfunction

  // Per-stage state, index 0 = input end, DEPTH-1 = output end.
  logic [DEPTH-1:0] v_p;
  logic [WIDTH-1:0] d_p [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] v_load;
  logic [DEPTH-1:0] v_nxt;
  logic [OCCW-1:0]  kill_n;

  // Ready ripples back from the output. An empty stage is always ready, so a
  // bubble anywhere lets everything upstream of it advance.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !v_p[i] | r;
      rdy[i] = r;
    end
  end

  // The source of stage i is stage i-1, or the upstream port for stage 0.
  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_p[i-1];
      src_d[i] = d_p[i-1];
    end
  end

  // v_load is what each stage would hold without flush. Flush only masks the
  // result, so data leaving a flushed stage still moves on to the next stage.
  // The counter counts exactly the entries that the mask removes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      v_load[i] = rdy[i] ? src_v[i] : v_p[i];
    end
    v_nxt  = v_load & ~flush;
    kill_n = popcount(v_load & flush);
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_p       <= '0;
      occupancy <= '0;
      flush_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_p[i] <= '0;
      end
    end else begin
      v_p       <= v_nxt;
      occupancy <= popcount(v_nxt);
      flush_cnt <= flush_cnt_clr ? '0 : sat_add(flush_cnt, kill_n);
      // Payload loads only when a valid entry arrives. A passing bubble
      // leaves the stale payload in place, and nothing reads it.
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && src_v[i]) begin
          d_p[i] <= src_d[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_p[DEPTH-1];
  assign out_data  = d_p[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain.sv
// Directed testbench for pipe_chain (WIDTH=32, DEPTH=4, CNTW=4).
// Runs one task per scenario, and each task checks its own results.
module tb_pipe_chain;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [D-1:0]  flush;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] flush_cnt;
  logic          flush_cnt_clr;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_chain #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flush        (flush),
    .occupancy    (occupancy),
    .flush_cnt    (flush_cnt),
    .flush_cnt_clr(flush_cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = '0; flush_cnt_clr = 1'b0;
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = '0; flush_cnt_clr = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL rst_occupancy: got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd0) $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt); else n_pass++;
    // While reset is held, a clock edge with offered data must change nothing.
    in_valid = 1'b1; in_data = 32'hDEAD;
    tick();
    n_checks++; if (occupancy !== 3'd0) $display("FAIL rst_hold_occupancy: got %0d want 0", occupancy); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    do_reset();
    in_valid = 1'b1; in_data = 32'd1; out_ready = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      in_data = W'(e + 2);
      n_checks++;
      if (out_valid !== (e >= 3)) $display("FAIL stream_valid e=%0d: got %b want %b", e, out_valid, (e >= 3));
      else n_pass++;
      if (e >= 3) begin
        n_checks++;
        if (out_data !== W'(e - 2)) $display("FAIL stream_data e=%0d: got %0d want %0d", e, out_data, e - 2);
        else n_pass++;
      end
      n_checks++;
      if (occupancy !== OW'((e >= 3) ? 4 : e + 1))
        $display("FAIL stream_occ e=%0d: got %0d want %0d", e, occupancy, (e >= 3) ? 4 : e + 1);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data = 32'hA0 + W'(j);
      tick();
    end
    in_data = 32'hBB;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_data !== 32'hA0) $display("FAIL stall_data: got %h want a0", out_data); else n_pass++;
    n_checks++; if (occupancy !== 3'd4) $display("FAIL stall_occ: got %0d want 4", occupancy); else n_pass++;
    tick();
    tick();
    n_checks++; if (out_data !== 32'hA0) $display("FAIL stall_hold_data: got %h want a0", out_data); else n_pass++;
    n_checks++; if (occupancy !== 3'd4) $display("FAIL stall_hold_occ: got %0d want 4", occupancy); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0 + W'(j))
        $display("FAIL stall_drain j=%0d: got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, 32'hA0 + W'(j));
      else n_pass++;
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_empty_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL stall_empty_occ: got %0d want 0", occupancy); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_bubble_collapse();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1111;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'h2222;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (dut.v_p !== 4'b0101) $display("FAIL bubble_pattern: got %b want 0101", dut.v_p); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bubble_in_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    tick();
    n_checks++; if (dut.v_p !== 4'b1100) $display("FAIL bubble_packed: got %b want 1100", dut.v_p); else n_pass++;
    n_checks++; if (occupancy !== 3'd2) $display("FAIL bubble_occ: got %0d want 2", occupancy); else n_pass++;
    n_checks++; if (out_data !== 32'h1111) $display("FAIL bubble_head: got %h want 1111", out_data); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2222)
      $display("FAIL bubble_second: got v=%b d=%h want v=1 d=2222", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bubble_empty: got %b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_branch_squash();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_data = 32'h55; flush = 4'b0011;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL squash_in_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    flush = '0; in_valid = 1'b0;
    n_checks++; if (dut.v_p !== 4'b0100) $display("FAIL squash_valid: got %b want 0100", dut.v_p); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd2) $display("FAIL squash_cnt: got %0d want 2", flush_cnt); else n_pass++;
    n_checks++; if (occupancy !== 3'd1) $display("FAIL squash_occ: got %0d want 1", occupancy); else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11)
      $display("FAIL squash_survivor: got v=%b d=%h want v=1 d=11", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL squash_drained: got %b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_cnt_saturation();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h99; flush = 4'b0001;
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_checks++;
      if (flush_cnt !== CW'((n < 15) ? n : 15))
        $display("FAIL sat_cnt n=%0d: got %0d want %0d", n, flush_cnt, (n < 15) ? n : 15);
      else n_pass++;
    end
    flush_cnt_clr = 1'b1;
    tick();
    flush_cnt_clr = 1'b0;
    n_checks++; if (flush_cnt !== 4'd0) $display("FAIL sat_clear: got %0d want 0", flush_cnt); else n_pass++;
    tick();
    n_checks++; if (flush_cnt !== 4'd1) $display("FAIL sat_after_clear: got %0d want 1", flush_cnt); else n_pass++;
    flush = '0; in_valid = 1'b0;
    tick();
    n_checks++; if (occupancy !== 3'd0) $display("FAIL sat_occ: got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd1) $display("FAIL sat_idle_cnt: got %0d want 1", flush_cnt); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; flush = 4'b0001;
    tick();
    flush = '0;
    for (int j = 0; j < 4; j++) begin
      in_data = 32'hC0 + W'(j);
      tick();
    end
    n_checks++; if (occupancy !== 3'd4) $display("FAIL ares_full_occ: got %0d want 4", occupancy); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd1) $display("FAIL ares_pre_cnt: got %0d want 1", flush_cnt); else n_pass++;
    n_checks++; if (out_data !== 32'hC0) $display("FAIL ares_pre_data: got %h want c0", out_data); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ares_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (occupancy !== 3'd0) $display("FAIL ares_occ: got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (flush_cnt !== 4'd0) $display("FAIL ares_cnt: got %0d want 0", flush_cnt); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL ares_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ares_in_ready: got %b want 1", in_ready); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h101; out_ready = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      in_data = 32'h102 + W'(e);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h101)
      $display("FAIL ares_resume0: got v=%b d=%h want v=1 d=101", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h102)
      $display("FAIL ares_resume1: got v=%b d=%h want v=1 d=102", out_valid, out_data);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_full_stall();
    test_bubble_collapse();
    test_branch_squash();
    test_cnt_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised elastic pipeline register chain with DEPTH stages, each WIDTH bits wide.
- Replaces the fixed, always-advancing inter-stage latches of the 5-stage CPU with one generic block. Each stage carries its own valid bit, and the chain supports valid/ready backpressure, bubble collapsing and per-stage flush.
- Also reports stage occupancy and keeps a saturating count of flushed entries, for hazard and branch-squash debugging.

Parameters:
- WIDTH, 32: payload bits per stage (instruction, PC, control bundle, etc.); legal range 1..256.
- DEPTH, 4: number of register stages; legal range 1..8.
- CNTW, 16: width of the flush counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream offers in_data.
- in_ready, output, 1: chain accepts in_data this cycle.
- in_data, input, WIDTH: payload entering stage 0.
- out_valid, output, 1: stage DEPTH-1 holds valid data.
- out_ready, input, 1: downstream consumes out_data this cycle (deassert = stall).
- out_data, output, WIDTH: payload of stage DEPTH-1.
- flush, input, DEPTH: bit i kills stage i at the next edge.
- occupancy, output, clog2(DEPTH+1): number of valid stages.
- flush_cnt, output, CNTW: saturating count of valid entries destroyed by flush.
- flush_cnt_clr, input, 1: synchronous clear of flush_cnt.

Behaviour:
- State: v[i] (valid) and d[i] (payload) for i = 0..DEPTH-1. Stage 0 is the input end; stage DEPTH-1 is the output.
- Reset (rst = 0, asynchronous):
  - All v[i] = 0 and all d[i] = 0; flush_cnt = 0.
  - Outputs during reset: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
  - Reset asserted mid-transfer drops all contents; no partial state survives.
- Ready chain (combinational, bubble-collapsing):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0].
- Stage transfer at the clock edge:
  - Stage i loads from stage i-1 (or from in_data when i = 0) when rdy[i] = 1.
  - New v[i] = v[i-1] (or in_valid when i = 0).
  - New d[i] = source payload when the source is valid; otherwise d[i] holds.
  - When rdy[i] = 0, stage i holds v[i] and d[i].
  - When the source is invalid and rdy[i] = 1, v[i] goes to 0 (a bubble advances).
- Output: out_data = d[DEPTH-1]; out_valid = v[DEPTH-1]. A consume happens when out_valid & out_ready.
- Latency: an entry accepted at edge k appears on out_valid after edge k+DEPTH-1 if there is no stall. Throughput is 1 entry per cycle.
- Flush:
  - flush[i] forces v[i] = 0 after the edge, overriding any load into stage i. Data arriving into a flushed stage is discarded.
  - Data leaving stage i in the same cycle is not affected; it moves on to stage i+1 unless flush[i+1] is also set.
  - flush[0] with in_valid & in_ready: the upstream handshake still completes and the entry is discarded.
  - flush[DEPTH-1] with a consume in the same cycle: the consume completes; the new contents of stage DEPTH-1 are killed.
  - flush affects valid bits only; d[i] is don't-care once its valid bit is cleared.
- Flush counter:
  - At each edge, flush_cnt increases by the number of stages i where flush[i] = 1 and the entry that would occupy stage i after the edge is valid.
  - The counter saturates at 2^CNTW-1 and never wraps.
  - flush_cnt_clr has priority: the counter is set to 0 and that cycle's increment is discarded.
- occupancy: registered popcount of v[], updated at the same edge as v[]; it always equals the count of valid stages.
- No entry is ever duplicated or lost except through flush or reset.
- DEPTH = 1 is legal: a single stage whose ready is !v[0] | out_ready.

Test Plan:
- Streaming: DEPTH=4, WIDTH=32, in_valid held high with data 1,2,3,...; out_ready=1. Required: first out_valid with data 1 after edge 3, then one consecutive value per cycle; occupancy = 4 in steady state.
- Full stall: fill 4 entries (0xA0..0xA3), then out_ready=0 and in_valid=1. Required: in_ready=0, out_data=0xA0 held, occupancy=4. On releasing out_ready, 0xA0..0xA3 leave in order with none lost.
- Bubble collapse: stage pattern v = 1,0,1,0 with out_ready=0. Required: in_ready=1; after 2 edges with in_valid=0, v = 0,0,1,1 (entries packed at the output end).
- Branch squash: stages 0 and 1 valid, flush=4'b0011 for one cycle, in_valid=1 with data 0x55. Required: 0x55 accepted (in_ready=1) but discarded; stages 0 and 1 invalid; flush_cnt increments by 2.
- Counter saturation and clear: CNTW=4 with flush=1 on 20 valid cycles. Required: flush_cnt stops at 15. Then flush_cnt_clr together with a flush: flush_cnt = 0 after the edge.
- Async reset mid-stream: pull rst low between edges while full. Required: out_valid=0, occupancy=0 and flush_cnt=0 immediately, without waiting for a clock edge; streaming resumes cleanly after rst returns high.
